// File: rtl/fifo_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_arbiter
// Description : Drains NUM_FIFOS upstream synchronous FIFOs into a single
//               registered valid/ready output stage. Selection is
//               round-robin, starting one past the last FIFO granted.
//               Throughput is one entry per cycle.
//               Optional macro FIFO_ARB_BURST_EN: the last granted FIFO keeps
//               priority for up to BURST_LEN consecutive grants (ARB/BURST
//               FSM). Without the macro the arbiter is pure per-entry
//               round-robin and no burst counter is built.
// Ports       : clk       - single clock, rising edge
//               rstb      - asynchronous active-low reset
//               enable    - while low, no new FIFO reads are issued
//               fifoEmpty - per-FIFO empty flags (authoritative)
//               fifoOut   - per-FIFO head data, FIFO i at [i*DATA_WIDTH +: DATA_WIDTH]
//               fifoRead  - one-hot-or-zero read strobes (combinational)
//               outReady  - downstream can accept
//               outValid  - outData/outSrc hold a valid entry
//               outData   - registered granted entry
//               outSrc    - index of the FIFO that supplied outData
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_arbiter #(
    parameter int NUM_FIFOS  = 4,
    parameter int DATA_WIDTH = 91,
    parameter int IDX_WIDTH  = 3,
    parameter int BURST_LEN  = 4
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            enable,
    input  logic [NUM_FIFOS-1:0]            fifoEmpty,
    input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifoOut,
    output logic [NUM_FIFOS-1:0]            fifoRead,
    input  logic                            outReady,
    output logic                            outValid,
    output logic [DATA_WIDTH-1:0]           outData,
    output logic [IDX_WIDTH-1:0]            outSrc
);

    // Elaboration-time legality check of the parameter set.
    generate
        if ((NUM_FIFOS < 2) || (NUM_FIFOS > 8) || ((2 ** IDX_WIDTH) < NUM_FIFOS) ||
            (BURST_LEN < 1) || (BURST_LEN > 15)) begin : g_bad_params
            $error("fifo_read_arbiter: illegal parameter combination");
        end
    endgenerate

    logic [NUM_FIFOS-1:0]  w_req;
    logic                  w_slot_free;
    logic [IDX_WIDTH-1:0]  r_last;
    logic                  w_above_found;
    logic [IDX_WIDTH-1:0]  w_above_idx;
    logic                  w_any_found;
    logic [IDX_WIDTH-1:0]  w_any_idx;
    logic [IDX_WIDTH-1:0]  w_rr_idx;
    logic                  w_hold;
    logic [IDX_WIDTH-1:0]  w_gnt_idx;
    logic                  w_grant;
    logic [DATA_WIDTH-1:0] w_gnt_data;

    assign w_req       = ~fifoEmpty;
    assign w_slot_free = ~outValid | outReady;

    // Round-robin search starting at r_last+1 (mod NUM_FIFOS), done as two
    // priority passes: the lowest requester above r_last wins; if there is
    // none, the search has wrapped and the lowest requester overall wins.
    // Iterating downward lets the lowest index overwrite higher ones.
    always_comb begin : p_rr_search
        w_above_found = 1'b0;
        w_above_idx   = '0;
        w_any_found   = 1'b0;
        w_any_idx     = '0;
        for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_any_found = 1'b1;
                w_any_idx   = IDX_WIDTH'(i);
                if (IDX_WIDTH'(i) > r_last) begin
                    w_above_found = 1'b1;
                    w_above_idx   = IDX_WIDTH'(i);
                end
            end
        end
    end

    assign w_rr_idx = w_above_found ? w_above_idx : w_any_idx;

`ifdef FIFO_ARB_BURST_EN
    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [3:0] c_BURST_MAX = 4'(BURST_LEN);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_last_req;

    always_comb begin : p_last_req
        w_last_req = 1'b0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (IDX_WIDTH'(i) == r_last) begin
                w_last_req = w_req[i];
            end
        end
    end

    // The burst owner keeps priority while it still has data and its
    // allowance is not used up; otherwise normal round-robin applies.
    assign w_hold = (r_state == BURST) && w_last_req && (r_cnt < c_BURST_MAX);

    always_ff @(posedge clk or negedge rstb) begin : p_fsm_reg
        if (!rstb) begin
            r_state <= ARB;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin : p_fsm_nxt
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_grant) begin
            // A round-robin grant (re)starts a burst on the winner.
            w_state_nxt = BURST;
            w_cnt_nxt   = w_hold ? (r_cnt + 4'd1) : 4'd1;
        end else if ((r_state == BURST) && !w_hold) begin
            w_state_nxt = ARB;
            w_cnt_nxt   = '0;
        end
    end
`else
    assign w_hold = 1'b0;
`endif

    assign w_gnt_idx = w_hold ? r_last : w_rr_idx;
    assign w_grant   = enable & w_slot_free & (w_hold | w_any_found);

    // Read strobe and data mux share the same decode of the grant index.
    // fifoRead is additionally forced low while reset is asserted.
    always_comb begin : p_read_strobe
        fifoRead   = '0;
        w_gnt_data = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (w_grant && (w_gnt_idx == IDX_WIDTH'(i))) begin
                fifoRead[i] = rstb;
                w_gnt_data  = fifoOut[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin : p_out_reg
        if (!rstb) begin
            outValid <= 1'b0;
            outData  <= '0;
            outSrc   <= '0;
            r_last   <= IDX_WIDTH'(NUM_FIFOS - 1);
        end else if (w_grant) begin
            // A grant both fills an empty slot and replaces an entry being
            // consumed this cycle, so valid stays high at full throughput.
            outValid <= 1'b1;
            outData  <= w_gnt_data;
            outSrc   <= w_gnt_idx;
            r_last   <= w_gnt_idx;
        end else if (outValid && outReady) begin
            outValid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_read_arbiter
// Description : Self-checking bench for fifo_read_arbiter: directed vector
//               table, multi-cycle sequences and randomized traffic checked
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_arbiter;

    localparam int NF = 4;
    localparam int DW = 91;
    localparam int IW = 3;
    localparam int BL = 4;

    logic             clk;
    logic             rstb;
    logic             enable;
    logic [NF-1:0]    fifoEmpty;
    logic [NF*DW-1:0] fifoOut;
    logic [NF-1:0]    fifoRead;
    logic             outReady;
    logic             outValid;
    logic [DW-1:0]    outData;
    logic [IW-1:0]    outSrc;

    fifo_read_arbiter #(
        .NUM_FIFOS  (NF),
        .DATA_WIDTH (DW),
        .IDX_WIDTH  (IW),
        .BURST_LEN  (BL)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .enable    (enable),
        .fifoEmpty (fifoEmpty),
        .fifoOut   (fifoOut),
        .fifoRead  (fifoRead),
        .outReady  (outReady),
        .outValid  (outValid),
        .outData   (outData),
        .outSrc    (outSrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] q [NF][$];
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_src;
    int            m_last;
    int            m_cnt;
    bit            m_burst;

    function automatic void m_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_last  = NF - 1;
        m_cnt   = 0;
        m_burst = 1'b0;
    endfunction

    function automatic bit m_hold();
`ifdef FIFO_ARB_BURST_EN
        return m_burst && (q[m_last].size() > 0) && (m_cnt < BL);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_pick();
        int idx;
        if (!rstb || !enable || (m_valid && !outReady)) return -1;
        if (m_hold()) return m_last;
        for (int k = 1; k <= NF; k++) begin
            idx = (m_last + k) % NF;
            if (q[idx].size() > 0) return idx;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom(), $urandom(), $urandom()});
    endfunction

    function automatic logic [DW-1:0] pat(input int r, input int i);
        logic [DW-1:0] d;
        d = '0;
        d[31:0]      = 32'hC0DE_0000 | 32'(r * 16 + i);
        d[DW-1 -: 32] = 32'hBEEF_0000 | 32'(i * 256 + r);
        return d;
    endfunction

    task automatic drive_fifos();
        for (int i = 0; i < NF; i++) begin
            fifoEmpty[i] = (q[i].size() == 0);
            fifoOut[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : '0;
        end
    endtask

    // One cycle against the model; entered and left at posedge+1.
    task automatic qstep();
        int            g;
        bit            h;
        logic [NF-1:0] er;
        drive_fifos();
        #1;
        g  = m_pick();
        h  = m_hold();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("fifoRead", 128'(fifoRead), 128'(er));
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_cnt   = (h && (g == m_last)) ? m_cnt + 1 : 1;
            m_burst = 1'b1;
            m_data  = q[g].pop_front();
            m_src   = g;
            m_last  = g;
            m_valid = 1'b1;
        end else begin
            if (m_burst && !h) begin
                m_burst = 1'b0;
                m_cnt   = 0;
            end
            if (m_valid && outReady) m_valid = 1'b0;
        end
        chk("outValid", 128'(outValid), 128'(m_valid));
        if (m_valid) begin
            chk("outSrc", 128'(outSrc), 128'(m_src));
            chk("outData", 128'(outData), 128'(m_data));
        end
    endtask

    // Entered at posedge+1; reset takes effect asynchronously.
    task automatic do_reset();
        rstb = 1'b0;
        #1;
        chk("rst_outValid", 128'(outValid), 128'(0));
        chk("rst_fifoRead", 128'(fifoRead), 128'(0));
        chk("rst_outData", 128'(outData), 128'(0));
        chk("rst_outSrc", 128'(outSrc), 128'(0));
        m_reset();
        @(posedge clk);
        #1;
        rstb = 1'b1;
    endtask

    typedef struct {
        logic          en;
        logic          rdy;
        logic [NF-1:0] empty;
        logic [NF-1:0] exp_read;
        logic          exp_valid;
        int            exp_src;
    } vec_t;

    initial begin
        vec_t          tbl [0:20];
        logic [DW-1:0] exp_data;
        int            exp_seq [8];
        int            n;

        m_reset();
        exp_data = '0;
        rstb     = 1'b1;
        enable   = 1'b1;
        outReady = 1'b1;
        fifoEmpty = '0;
        fifoOut   = '1;
        #2 rstb = 1'b0;
        #10;
        // Every FIFO requests and enable is high, yet reset must hold all off.
        chk("init_fifoRead", 128'(fifoRead), 128'(0));
        chk("init_outValid", 128'(outValid), 128'(0));
        chk("init_outData", 128'(outData), 128'(0));
        chk("init_outSrc", 128'(outSrc), 128'(0));
        @(posedge clk);
        #1;
        fifoEmpty = '1;
        rstb = 1'b1;

`ifndef FIFO_ARB_BURST_EN
        tbl = '{
            '{1'b1, 1'b1, 4'b1010, 4'b0001, 1'b1, 0},   // FIFOs 0,2 x2 entries
            '{1'b1, 1'b1, 4'b1010, 4'b0100, 1'b1, 2},
            '{1'b1, 1'b1, 4'b1010, 4'b0001, 1'b1, 0},
            '{1'b1, 1'b1, 4'b1011, 4'b0100, 1'b1, 2},
            '{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 0},   // all empty
            '{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 0},
            '{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 0},
            '{1'b1, 1'b1, 4'b1110, 4'b0001, 1'b1, 0},
            '{1'b0, 1'b1, 4'b1110, 4'b0000, 1'b0, 0},   // enable dropped
            '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 0},
            '{1'b1, 1'b1, 4'b1101, 4'b0010, 1'b1, 1},
            '{1'b1, 1'b0, 4'b1000, 4'b0000, 1'b1, 1},   // backpressure x5
            '{1'b1, 1'b0, 4'b1000, 4'b0000, 1'b1, 1},
            '{1'b1, 1'b0, 4'b1000, 4'b0000, 1'b1, 1},
            '{1'b1, 1'b0, 4'b1000, 4'b0000, 1'b1, 1},
            '{1'b1, 1'b0, 4'b1000, 4'b0000, 1'b1, 1},
            '{1'b1, 1'b1, 4'b1000, 4'b0100, 1'b1, 2},
            '{1'b1, 1'b1, 4'b0111, 4'b1000, 1'b1, 3},
            '{1'b1, 1'b1, 4'b0111, 4'b1000, 1'b1, 3},   // same FIFO back to back
            '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b1, 3},
            '{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 0}
        };
        for (int r = 0; r <= 20; r++) begin
            enable    = tbl[r].en;
            outReady  = tbl[r].rdy;
            fifoEmpty = tbl[r].empty;
            for (int i = 0; i < NF; i++) fifoOut[i*DW +: DW] = pat(r, i);
            #1;
            chk($sformatf("vec%0d_fifoRead", r), 128'(fifoRead), 128'(tbl[r].exp_read));
            if (tbl[r].exp_read != '0) exp_data = pat(r, tbl[r].exp_src);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_outValid", r), 128'(outValid), 128'(tbl[r].exp_valid));
            if (tbl[r].exp_valid) begin
                chk($sformatf("vec%0d_outSrc", r), 128'(outSrc), 128'(tbl[r].exp_src));
                chk($sformatf("vec%0d_outData", r), 128'(outData), 128'(exp_data));
            end
        end
        exp_seq = '{1, 3, 1, 3, 1, 1, 1, 1};
`else
        exp_seq = '{1, 1, 1, 1, 3, 3, 1, 1};
`endif

        // FIFO 1 with 6 entries, FIFO 3 with 2 entries.
        do_reset();
        for (int k = 0; k < 6; k++) q[1].push_back(rnd_data());
        for (int k = 0; k < 2; k++) q[3].push_back(rnd_data());
        enable   = 1'b1;
        outReady = 1'b1;
        for (int s = 0; s < 8; s++) begin
            qstep();
            chk($sformatf("seq%0d_outSrc", s), 128'(outSrc), 128'(exp_seq[s]));
        end
        qstep();
        chk("seq_drained", 128'(outValid), 128'(0));

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NF; i++) begin
                if ((q[i].size() < 6) && ($urandom_range(0, 99) < 30))
                    q[i].push_back(rnd_data());
            end
            enable   = ($urandom_range(0, 9) != 0);
            outReady = ($urandom_range(0, 9) < 7);
            qstep();
        end

        // Reset pulsed while an entry is held.
        enable   = 1'b1;
        outReady = 1'b0;
        q[2].push_back(rnd_data());
        n = 0;
        while (!m_valid && (n < 20)) begin
            qstep();
            n++;
        end
        chk("pre_reset_outValid", 128'(outValid), 128'(1));
        q[0].delete();
        q[1].delete();
        q[2].push_back(rnd_data());
        q[3].push_back(rnd_data());
        drive_fifos();
        do_reset();
        outReady = 1'b1;
        qstep();
        chk("post_reset_first_src", 128'(outSrc), 128'(2));

        // Everything empty: nothing may ever be read or presented.
        for (int i = 0; i < NF; i++) q[i].delete();
        enable = 1'b1;
        for (int c = 0; c < 10; c++) qstep();
        chk("idle_outValid", 128'(outValid), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_read_arbiter.md
FIFO_READ_ARBITER -- requirements
Module: fifo_read_arbiter

Interface
REQ-001 SHALL have parameter NUM_FIFOS, default 4, number of upstream synchronous FIFOs drained (legal 2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 91, width of one FIFO entry.
REQ-003 SHALL have parameter IDX_WIDTH, default 3, width of the source index (2^IDX_WIDTH >= NUM_FIFOS).
REQ-004 SHALL have parameter BURST_LEN, default 4, maximum consecutive grants to one FIFO (legal 1..15; used only when the Configuration macro is defined).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rstb, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1; while low, no new FIFO reads are issued.
REQ-008 SHALL have port fifoEmpty, input, NUM_FIFOS, per-FIFO empty flags.
REQ-009 SHALL have port fifoOut, input, NUM_FIFOS*DATA_WIDTH, per-FIFO head data; FIFO i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port fifoRead, output, NUM_FIFOS, one-hot-or-zero read strobes, one per FIFO.
REQ-011 SHALL have port outReady, input, 1, downstream can accept.
REQ-012 SHALL have port outValid, output, 1, outData/outSrc hold a valid entry.
REQ-013 SHALL have port outData, output, DATA_WIDTH, registered granted entry.
REQ-014 SHALL have port outSrc, output, IDX_WIDTH, index of the FIFO that supplied outData.

Function
REQ-015 SHALL define slotFree = ~outValid | outReady; a grant is issued only when enable & slotFree & at least one fifoEmpty bit is 0.
REQ-016 SHALL be round-robin: the search starts at lastGrant+1 modulo NUM_FIFOS, and the first non-empty FIFO wins; lastGrant resets to NUM_FIFOS-1, so FIFO 0 wins first.
REQ-017 SHALL drive fifoRead[g] combinationally high in the grant cycle and never assert more than one bit; fifoRead = 0 with no grant.
REQ-018 SHALL, on the edge ending a grant cycle, load outData with fifoOut slice g as sampled in that cycle, load outSrc with g, set outValid to 1, and set lastGrant to g. Latency from grant to outValid is 1 cycle.
REQ-019 SHALL clear outValid when outValid & outReady and no grant occurs in the same cycle.
REQ-020 SHALL, with outValid & outReady & grant in the same cycle, replace the output with the new entry and keep outValid high. Full throughput is one entry per cycle.
REQ-021 SHALL hold outData/outSrc stable while outValid & ~outReady.
REQ-022 SHALL permit consecutive-cycle grants to the same FIFO, relying on fifoEmpty updating on the edge after a read.
REQ-023 SHALL treat fifoEmpty as authoritative; a FIFO whose flag is 1 is never read, even if it is the only requester.
REQ-024 SHALL, when enable falls, stop issuing grants immediately, drain any held output normally, and keep lastGrant unchanged.

Reset
REQ-025 SHALL, on rstb low, asynchronously set outValid=0, outData=0, outSrc=0, lastGrant=NUM_FIFOS-1, burst count=0, and state=ARB; fifoRead SHALL be 0 while rstb is low.
REQ-026 SHALL, after reset is released mid-operation, resume arbitration from FIFO 0 with no replay of entries lost at reset.

Configuration
REQ-027 SHALL, with FIFO_ARB_BURST_EN defined, use FSM states ARB and BURST: a grant in ARB moves to BURST with count=1. In BURST, lastGrant keeps priority while it is non-empty and count<BURST_LEN, incrementing count per grant. The FSM returns to ARB when lastGrant is empty or count reaches BURST_LEN; the next search then starts at lastGrant+1.
REQ-028 SHALL, without FIFO_ARB_BURST_EN, stay permanently in ARB, giving pure per-entry round-robin; BURST_LEN is ignored and no burst counter is built.

Verification
REQ-029 SHALL cover: reset, then FIFOs 0 and 2 non-empty with 2 entries each, outReady=1, macro off -> outSrc sequence 0,2,0,2 on consecutive cycles, then outValid=0.
REQ-030 SHALL cover: outValid=1 with outReady=0 held for 5 cycles -> fifoRead=0 and outData/outSrc unchanged for all 5 cycles.
REQ-031 SHALL cover: all FIFOs empty, enable=1 -> fifoRead=0 and outValid=0 indefinitely.
REQ-032 SHALL cover: macro on, BURST_LEN=4, FIFO 1 holds 6 entries, FIFO 3 holds 2 entries -> outSrc sequence 1,1,1,1,3,3,1,1.
REQ-033 SHALL cover: rstb pulsed low mid-stream while outValid=1 -> outValid=0 immediately; the first grant after release goes to the lowest-index non-empty FIFO.
REQ-034 SHALL cover: enable dropped with outValid=1, outReady=1 -> the held entry is delivered once, then fifoRead=0 and outValid=0 until enable returns.
